// File: rtl/rram_instr_fifo.sv
// First-word-fall-through instruction FIFO feeding the RRAM crossbar controller; 1-cycle write-to-read latency.
// Optional sticky overflow/underflow flags are built only when RRAM_INSTR_FIFO_ERR_EN is defined.
module rram_instr_fifo #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       push_n,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       pop_n_instFIFO,
  output logic                       empty_instFIFO,
  output logic [DATA_WIDTH-1:0]      dout_instFIFO,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full           = (count == CW'(DEPTH));
  assign empty_instFIFO = (count == '0);
  assign almost_full    = (count >= CW'(AF_LEVEL));

  // A push into a full FIFO or a pop from an empty one is simply refused.
  assign push_ok = !push_n && !full;
  assign pop_ok  = !pop_n_instFIFO && !empty_instFIFO;

  assign dout_instFIFO = empty_instFIFO ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push_ok && !pop_ok)
        count <= count + 1'b1;
      else if (pop_ok && !push_ok)
        count <= count - 1'b1;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_ok && !reset)
      mem[wr_ptr] <= din;
  end

`ifdef RRAM_INSTR_FIFO_ERR_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (!push_n && full)
        ovf_err <= 1'b1;
      if (!pop_n_instFIFO && empty_instFIFO)
        udf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_rram_instr_fifo.sv
// Directed bench for rram_instr_fifo: reset, FWFT timing, full/empty boundaries, wrap, error flags.
module tb_rram_instr_fifo;

`ifdef RRAM_INSTR_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        push_n;
  logic [19:0] din;
  logic        full;
  logic        almost_full;
  logic        pop_n;
  logic        empty;
  logic [19:0] dout;
  logic [4:0]  count;
  logic        ovf_err;
  logic        udf_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rram_instr_fifo #(.DATA_WIDTH(20), .DEPTH(16), .AF_LEVEL(14)) dut (
    .CLK            (clk),
    .reset          (reset),
    .push_n         (push_n),
    .din            (din),
    .full           (full),
    .almost_full    (almost_full),
    .pop_n_instFIFO (pop_n),
    .empty_instFIFO (empty),
    .dout_instFIFO  (dout),
    .count          (count),
    .ovf_err        (ovf_err),
    .udf_err        (udf_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input bit exp_ovf, input bit exp_udf);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".af"}, 32'(almost_full), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".dout"}, 32'(dout), 32'd0);
    chk({tag, ".ovf"}, 32'(ovf_err), 32'(exp_ovf));
    chk({tag, ".udf"}, 32'(udf_err), 32'(exp_udf));
  endtask

  initial begin
    bit exp_ovf;
    bit exp_udf;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    reset  = 1'b1;
    push_n = 1'b1;
    pop_n  = 1'b1;
    din    = '0;
    tick();
    tick();
    chk_idle("rst", 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_idle("post_rst", 1'b0, 1'b0);

    // single word: visible one edge after the push
    push_n = 1'b0; din = 20'h6_1000;
    tick();
    push_n = 1'b1;
    chk("one.empty", 32'(empty), 32'd0);
    chk("one.dout", 32'(dout), 32'h6_1000);
    chk("one.count", 32'(count), 32'd1);
    pop_n = 1'b0;
    tick();
    pop_n = 1'b1;
    chk_idle("one_pop", 1'b0, 1'b0);

    // fill to full, watch almost_full threshold
    for (int i = 0; i < 16; i++) begin
      push_n = 1'b0; din = 20'(i);
      tick();
      chk("fill.count", 32'(count), 32'(i + 1));
      chk("fill.af", 32'(almost_full), 32'(i + 1 >= 14));
      chk("fill.full", 32'(full), 32'(i + 1 == 16));
    end
    din = 20'hF_FFFF;
    tick();
    push_n = 1'b1;
    exp_ovf = ERR_EN;
    chk("ovf.count", 32'(count), 32'd16);
    chk("ovf.full", 32'(full), 32'd1);
    chk("ovf.flag", 32'(ovf_err), 32'(exp_ovf));
    chk("ovf.udf", 32'(udf_err), 32'd0);
    chk("ovf.head", 32'(dout), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("drain.dout", 32'(dout), 32'(i));
      pop_n = 1'b0;
      tick();
    end
    pop_n = 1'b1;
    chk_idle("drained", exp_ovf, 1'b0);

    // steady push+pop at occupancy 3, crossing pointer wraps twice
    for (int i = 0; i < 3; i++) begin
      push_n = 1'b0; din = 20'h100 + 20'(i);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      chk("stream.dout", 32'(dout), 32'h100 + 32'(k));
      push_n = 1'b0; pop_n = 1'b0; din = 20'h103 + 20'(k);
      tick();
      chk("stream.count", 32'(count), 32'd3);
    end
    push_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stream_tail.dout", 32'(dout), 32'h128 + 32'(i));
      tick();
    end
    pop_n = 1'b1;
    chk_idle("stream_done", exp_ovf, 1'b0);

    // full + simultaneous push/pop: pop wins, push dropped
    for (int i = 0; i < 16; i++) begin
      push_n = 1'b0; din = 20'h200 + 20'(i);
      tick();
    end
    din = 20'hA_BCDE; pop_n = 1'b0;
    tick();
    push_n = 1'b1; pop_n = 1'b1;
    chk("fullpp.count", 32'(count), 32'd15);
    chk("fullpp.full", 32'(full), 32'd0);
    chk("fullpp.dout", 32'(dout), 32'h201);
    for (int i = 0; i < 15; i++) begin
      chk("fullpp_drain.dout", 32'(dout), 32'h201 + 32'(i));
      pop_n = 1'b0;
      tick();
    end
    pop_n = 1'b1;
    chk_idle("fullpp_done", exp_ovf, 1'b0);

    // empty + simultaneous push/pop: push wins, pop flagged as underflow
    push_n = 1'b0; pop_n = 1'b0; din = 20'h3_3333;
    tick();
    push_n = 1'b1; pop_n = 1'b1;
    exp_udf = ERR_EN;
    chk("emptypp.count", 32'(count), 32'd1);
    chk("emptypp.dout", 32'(dout), 32'h3_3333);
    chk("emptypp.udf", 32'(udf_err), 32'(exp_udf));
    chk("emptypp.ovf", 32'(ovf_err), 32'(exp_ovf));
    pop_n = 1'b0;
    tick();
    pop_n = 1'b1;
    chk_idle("emptypp_done", exp_ovf, exp_udf);

    // asynchronous reset mid-burst at count 5
    for (int i = 0; i < 5; i++) begin
      push_n = 1'b0; din = 20'h400 + 20'(i);
      tick();
    end
    chk("burst.count", 32'(count), 32'd5);
    chk("burst.dout", 32'(dout), 32'h400);
    #1 reset = 1'b1;
    #1;
    chk_idle("async_rst", 1'b0, 1'b0);
    tick();
    chk_idle("rst_hold", 1'b0, 1'b0);
    reset = 1'b0; push_n = 1'b1;
    tick();
    chk_idle("rst_release", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rram_instr_fifo.md
# rram_instr_fifo

Instruction FIFO upstream of the RRAM crossbar controller FSM. It buffers {INSTR, OPCODE} words from the host/NoC side and presents them to the controller. The output uses a first-word-fall-through (FWFT) convention: `dout_instFIFO` is valid whenever `empty_instFIFO` is low, and `pop_n_instFIFO` is asserted low by the FSM to consume the word. All state updates occur on the single clock.

## Interface
- DATA_WIDTH, 20, word width (INSTR_WIDTH 4 + OPCODE_WIDTH 16).
- DEPTH, 16, number of entries; any value ≥ 2.
- AF_LEVEL, 14, `almost_full` asserts when occupancy ≥ AF_LEVEL.
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- push_n  in  1  active-low write request from host.
- din  in  DATA_WIDTH  write data, sampled when a push is accepted.
- full  out  1  FIFO holds DEPTH words.
- almost_full  out  1  occupancy ≥ AF_LEVEL.
- pop_n_instFIFO  in  1  active-low read request from controller.
- empty_instFIFO  out  1  FIFO holds 0 words.
- dout_instFIFO  out  DATA_WIDTH  head word (FWFT); 0 while empty.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ovf_err  out  1  sticky overflow flag.
- udf_err  out  1  sticky underflow flag.

## Operation
- Storage: DEPTH×DATA_WIDTH register array; `wr_ptr` and `rd_ptr` of width $clog2(DEPTH). Each pointer wraps explicitly from DEPTH-1 to 0, so non-power-of-2 depths are supported. `count` is a separate register.
- Accepted push: `push_n`=0 and `full`=0. Writes `din` to mem[`wr_ptr`] and increments `wr_ptr`.
- Accepted pop: `pop_n_instFIFO`=0 and `empty_instFIFO`=0. Increments `rd_ptr`.
- Push while full is dropped, even if a pop is accepted in the same cycle. No write-through.
- Pop while empty is ignored, even if a push is accepted in the same cycle. No read-through.
- Accepted push and accepted pop in the same cycle: both pointers advance and `count` is unchanged.
- Count update: `count` +1 on push only, −1 on pop only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- Flags, derived from registered `count`:
  - `full` = (count==DEPTH)
  - `empty_instFIFO` = (count==0)
  - `almost_full` = (count≥AF_LEVEL)
- `dout_instFIFO` = `empty_instFIFO` ? 0 : mem[`rd_ptr`]. This is a combinational read of registered state.
- Reset (asynchronous, any time, including mid-burst):
  - pointers = 0, `count` = 0, `empty_instFIFO` = 1, `full` = 0, `almost_full` = 0, `dout_instFIFO` = 0, `ovf_err` = 0, `udf_err` = 0.
  - Memory contents are not reset. Any in-flight push or pop on the reset edge is discarded.

## Timing
- Write-to-read latency is 1 cycle. A push accepted at edge k deasserts `empty_instFIFO` and presents the word on `dout_instFIFO` after edge k.
- Pop at edge k: the next word (or 0 with empty=1) appears after edge k. The controller may pop on consecutive cycles, giving 1 word/cycle sustained.
- All flags and `count` update on the same edge as the pointer change. There are no flag lag cycles.
- Inputs must be stable around the CLK rising edge. No combinational path from `push_n` or `din` to any output.

## Configuration
- RRAM_INSTR_FIFO_ERR_EN defined:
  - `ovf_err` sets on any edge with `push_n`=0 and `full`=1.
  - `udf_err` sets on any edge with `pop_n_instFIFO`=0 and `empty_instFIFO`=1.
  - Both flags are sticky until reset.
- Not defined: `ovf_err` and `udf_err` are tied to 0, and no error logic is synthesised. Ports remain present.

## Test plan
- Reset → `empty_instFIFO`=1, `full`=0, `count`=0, `dout_instFIFO`=20'h0. Assert `reset` mid-burst with count=5 → all return to these values asynchronously, before the next edge.
- Push 20'h6_1000 into empty FIFO with pop_n=1 → next cycle `empty_instFIFO`=0, `dout_instFIFO`=20'h6_1000, `count`=1. Pop → empty=1, dout=0.
- Push 16 words 20'h0_0000..20'h0_000F → `almost_full` rises at count 14, `full`=1 at 16. 17th push (20'hF_FFFF) dropped, with `ovf_err`=1 when RRAM_INSTR_FIFO_ERR_EN is defined. 16 pops return 0..F in order; pointers wrap cleanly.
- Simultaneous push+pop at count=3 for 40 cycles (incrementing data) → `count` stays 3 and output order is preserved across two pointer wraps.
- Full FIFO, push+pop same cycle → pop accepted, push dropped, count=15. Empty FIFO, push+pop same cycle → push accepted, count=1, `udf_err`=1 if the macro is defined.
- Build without RRAM_INSTR_FIFO_ERR_EN, repeat the overflow and underflow stimulus → `ovf_err` and `udf_err` stay 0 throughout.
